// File: rtl/oq_header_parser_pkg.sv
// Shared definitions for the output-queue header parser: IOQ header layout,
// the header ctrl marker, the parser state type and a ceiling-log2 helper.
package oq_header_parser_pkg;

    localparam logic [7:0] IOQ_HDR_CTRL = 8'hFF;

    localparam int DST_PORT_POS    = 48;
    localparam int WORD_LEN_POS    = 32;
    localparam int SRC_PORT_POS    = 16;
    localparam int BYTE_LEN_POS    = 0;
    localparam int HDR_FIELD_WIDTH = 16;

    typedef enum logic {
        ST_HDR,
        ST_PAYLOAD
    } parse_state_t;

    // Ceiling log2, so non-power-of-two queue counts still get enough index bits.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/oq_header_parser_dst_info_fifo.sv
// First-word-fallthrough FIFO holding one {dst_oq, byte_len, word_len} entry per packet.
// A write while full is dropped unless a read frees a slot in the same cycle.
module dst_info_fifo #(
    parameter int WIDTH      = 22,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_BITS:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  do_rd;
    logic                  do_wr;

    assign empty = (count == '0);
    assign full  = (count == (DEPTH_BITS+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head is presented combinationally; an empty FIFO reads as zero.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oq_header_parser.sv
// Snoops the input packet stream, decodes the IOQ header word and queues one entry per packet.
// Optional statistics counters are enabled with the OQ_HDR_PARSER_STATS_EN macro.
module oq_header_parser
    import oq_header_parser_pkg::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int NUM_OUTPUT_QUEUES   = 5,
    parameter int PKT_LEN_WIDTH       = 11,
    parameter int PKT_WORDS_WIDTH     = PKT_LEN_WIDTH - log2(CTRL_WIDTH),
    parameter int NUM_OQ_WIDTH        = log2(NUM_OUTPUT_QUEUES),
    parameter int DST_FIFO_DEPTH_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_wr,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [CTRL_WIDTH-1:0]      in_ctrl,
    output logic                       in_rdy,
    output logic                       dst_oq_avail,
    output logic [NUM_OQ_WIDTH-1:0]    parsed_dst_oq,
    output logic [PKT_LEN_WIDTH-1:0]   parsed_pkt_byte_len,
    output logic [PKT_WORDS_WIDTH-1:0] parsed_pkt_word_len,
    input  logic                       rd_dst_oq,
    output logic                       hdr_err,
    output logic                       entry_overflow
`ifdef OQ_HDR_PARSER_STATS_EN
    ,
    output logic [31:0]                num_hdrs_parsed,
    output logic [31:0]                num_hdr_errs,
    output logic [31:0]                num_overflows
`endif
);

    localparam int ENTRY_WIDTH = NUM_OQ_WIDTH + PKT_LEN_WIDTH + PKT_WORDS_WIDTH;
    localparam int FIFO_DEPTH  = 1 << DST_FIFO_DEPTH_BITS;

    parse_state_t               state;
    logic                       prev_ctrl_is_0;
    logic                       eop;
    logic                       pend_valid;
    logic [ENTRY_WIDTH-1:0]     pend_entry;

    logic [HDR_FIELD_WIDTH-1:0] hdr_dst_port;
    logic [HDR_FIELD_WIDTH-1:0] hdr_word_len;
    logic [HDR_FIELD_WIDTH-1:0] hdr_byte_len;
    logic                       ctrl_ok;
    logic                       parse_err;
    logic [NUM_OQ_WIDTH-1:0]    lowest_dst;
    logic [NUM_OQ_WIDTH-1:0]    entry_dst;
    logic [PKT_LEN_WIDTH-1:0]   entry_byte_len;
    logic [PKT_WORDS_WIDTH-1:0] entry_word_len;
    logic                       unused_hdr_bits;

    logic [ENTRY_WIDTH-1:0]         fifo_head;
    logic [DST_FIFO_DEPTH_BITS:0]   fifo_count;
    logic                           fifo_empty;
    logic                           fifo_full;

    assign hdr_dst_port = in_data[DST_PORT_POS +: HDR_FIELD_WIDTH];
    assign hdr_word_len = in_data[WORD_LEN_POS +: HDR_FIELD_WIDTH];
    assign hdr_byte_len = in_data[BYTE_LEN_POS +: HDR_FIELD_WIDTH];
    assign unused_hdr_bits = ^{in_data[SRC_PORT_POS +: HDR_FIELD_WIDTH],
                               hdr_dst_port[HDR_FIELD_WIDTH-1:NUM_OUTPUT_QUEUES]};

    assign ctrl_ok = (in_ctrl == CTRL_WIDTH'(IOQ_HDR_CTRL));
    assign eop     = in_wr && prev_ctrl_is_0 && (in_ctrl != '0);

    // Multicast is unsupported: the lowest set port bit wins.
    always_comb begin
        lowest_dst = '0;
        for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
            if (hdr_dst_port[i]) begin
                lowest_dst = NUM_OQ_WIDTH'(i);
            end
        end
    end

    // Malformed headers still yield an entry so the store stage stays one-per-packet.
    always_comb begin
        parse_err = !ctrl_ok
                 || (hdr_dst_port[NUM_OUTPUT_QUEUES-1:0] == '0)
                 || (|hdr_byte_len[HDR_FIELD_WIDTH-1:PKT_LEN_WIDTH])
                 || (|hdr_word_len[HDR_FIELD_WIDTH-1:PKT_WORDS_WIDTH]);
        entry_dst      = parse_err ? '0 : lowest_dst;
        entry_byte_len = ctrl_ok ? hdr_byte_len[PKT_LEN_WIDTH-1:0] : '0;
        entry_word_len = ctrl_ok ? hdr_word_len[PKT_WORDS_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_HDR;
            prev_ctrl_is_0 <= 1'b0;
            pend_valid     <= 1'b0;
            pend_entry     <= '0;
            hdr_err        <= 1'b0;
        end else begin
            pend_valid <= 1'b0;
            hdr_err    <= 1'b0;
            if (in_wr) begin
                prev_ctrl_is_0 <= (in_ctrl == '0);
                case (state)
                    ST_HDR: begin
                        pend_valid <= 1'b1;
                        pend_entry <= {entry_dst, entry_byte_len, entry_word_len};
                        hdr_err    <= parse_err;
                        state      <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        if (eop) begin
                            state <= ST_HDR;
                        end
                    end
                    default: state <= ST_HDR;
                endcase
            end
        end
    end

    dst_info_fifo #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH_BITS (DST_FIFO_DEPTH_BITS)
    ) u_dst_info_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pend_valid),
        .wr_data (pend_entry),
        .rd_en   (rd_dst_oq),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign {parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len} = fifo_head;
    assign dst_oq_avail   = !fifo_empty;
    assign entry_overflow = pend_valid && fifo_full && !rd_dst_oq;
    assign in_rdy         = (fifo_count <= (DST_FIFO_DEPTH_BITS+1)'(FIFO_DEPTH - 2));

`ifdef OQ_HDR_PARSER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            num_hdrs_parsed <= '0;
            num_hdr_errs    <= '0;
            num_overflows   <= '0;
        end else begin
            if (pend_valid) begin
                num_hdrs_parsed <= num_hdrs_parsed + 32'd1;
            end
            if (hdr_err) begin
                num_hdr_errs <= num_hdr_errs + 32'd1;
            end
            if (entry_overflow) begin
                num_overflows <= num_overflows + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_oq_header_parser.sv
// Scoreboard bench for oq_header_parser: stimulus pushes expected entries, a monitor pops them.
module tb_oq_header_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_wr;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_rdy;
    logic        dst_oq_avail;
    logic [2:0]  parsed_dst_oq;
    logic [10:0] parsed_pkt_byte_len;
    logic [7:0]  parsed_pkt_word_len;
    logic        rd_dst_oq;
    logic        hdr_err;
    logic        entry_overflow;
`ifdef OQ_HDR_PARSER_STATS_EN
    logic [31:0] num_hdrs_parsed;
    logic [31:0] num_hdr_errs;
    logic [31:0] num_overflows;
`endif

    typedef struct {
        logic [2:0]  dst;
        logic [10:0] bytes;
        logic [7:0]  words;
    } entry_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic [15:0] dp;
        logic [15:0] wl;
        logic [15:0] bl;
        logic [2:0]  dst;
        logic [10:0] bytes;
        logic [7:0]  words;
        int          err;
    } vec_t;

    entry_t exp_q[$];
    vec_t   vecs[8];
    int     total_checks  = 0;
    int     passed_checks = 0;
    int     err_seen      = 0;
    int     overflow_seen = 0;
    bit     auto_pop      = 1'b0;

    oq_header_parser dut (
        .clk                 (clk),
        .reset               (reset),
        .in_wr               (in_wr),
        .in_data             (in_data),
        .in_ctrl             (in_ctrl),
        .in_rdy              (in_rdy),
        .dst_oq_avail        (dst_oq_avail),
        .parsed_dst_oq       (parsed_dst_oq),
        .parsed_pkt_byte_len (parsed_pkt_byte_len),
        .parsed_pkt_word_len (parsed_pkt_word_len),
        .rd_dst_oq           (rd_dst_oq),
        .hdr_err             (hdr_err),
        .entry_overflow      (entry_overflow)
`ifdef OQ_HDR_PARSER_STATS_EN
        ,
        .num_hdrs_parsed     (num_hdrs_parsed),
        .num_hdr_errs        (num_hdr_errs),
        .num_overflows       (num_overflows)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [15:0] dp, input logic [15:0] wl, input logic [15:0] bl);
        return {dp, wl, 16'h0001, bl};
    endfunction

    task automatic expect_entry(input logic [2:0] dst, input logic [10:0] bytes, input logic [7:0] words);
        entry_t e;
        e.dst   = dst;
        e.bytes = bytes;
        e.words = words;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [7:0] c, input logic [63:0] d);
        @(negedge clk);
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Header, one ctrl==0 data word, then a ctrl!=0 end word.
    task automatic send_pkt(input logic [7:0] c, input logic [63:0] hdr);
        send_word(c, hdr);
        send_word(8'h00, 64'h1111_2222_3333_4444);
        send_word(8'h01, 64'h5555_6666_7777_8888);
    endtask

    task automatic drain();
        auto_pop = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("drain_avail", dst_oq_avail, 0);
    endtask

    // Error and overflow pulse counters.
    initial begin
        forever @(negedge clk) begin
            if (hdr_err === 1'b1) err_seen++;
            if (entry_overflow === 1'b1) overflow_seen++;
        end
    end

    // Monitor: pops and compares the head entry whenever popping is enabled.
    initial begin
        entry_t e;
        rd_dst_oq = 1'b0;
        forever @(negedge clk) begin
            rd_dst_oq = 1'b0;
            if (reset === 1'b0 && auto_pop && dst_oq_avail === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_checks++;
                    $display("[TB] FAIL unexpected_entry: got dst %0d, expected no entry", parsed_dst_oq);
                end else begin
                    e = exp_q.pop_front();
                    check("entry_dst", parsed_dst_oq, e.dst);
                    check("entry_bytes", parsed_pkt_byte_len, e.bytes);
                    check("entry_words", parsed_pkt_word_len, e.words);
                end
                rd_dst_oq = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int err_before;
        vecs[0] = '{8'hFF, 16'h0006, 16'd13,    16'd100,   3'd1, 11'd100,  8'd13,  0};
        vecs[1] = '{8'hFF, 16'h0000, 16'd8,     16'd64,    3'd0, 11'd64,   8'd8,   1};
        vecs[2] = '{8'h00, 16'h0004, 16'd8,     16'd60,    3'd0, 11'd0,    8'd0,   1};
        vecs[3] = '{8'hFF, 16'h0010, 16'h00FF,  16'h07FF,  3'd4, 11'd2047, 8'd255, 0};
        vecs[4] = '{8'hFF, 16'h0002, 16'd5,     16'h0800,  3'd0, 11'd0,    8'd5,   1};
        vecs[5] = '{8'hFF, 16'h0001, 16'h0100,  16'd20,    3'd0, 11'd20,   8'd0,   1};
        vecs[6] = '{8'hFF, 16'h0020, 16'd3,     16'd30,    3'd0, 11'd30,   8'd3,   1};
        vecs[7] = '{8'hFF, 16'h8003, 16'd2,     16'd16,    3'd0, 11'd16,   8'd2,   0};

        reset   = 1'b1;
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avail", dst_oq_avail, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_hdr_err", hdr_err, 0);
        check("rst_overflow", entry_overflow, 0);
        check("rst_dst", parsed_dst_oq, 0);
        check("rst_bytes", parsed_pkt_byte_len, 0);
        check("rst_words", parsed_pkt_word_len, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic header: entry visible two edges after the header is presented.
        expect_entry(3'd2, 11'd60, 8'd8);
        send_word(8'hFF, mk_hdr(16'h0004, 16'd8, 16'd60));
        @(posedge clk);
        #1;
        check("t1_hdr_err", hdr_err, 0);
        check("t1_avail_early", dst_oq_avail, 0);
        idle(1);
        @(posedge clk);
        #1;
        check("t1_avail", dst_oq_avail, 1);
        check("t1_dst", parsed_dst_oq, 2);
        check("t1_bytes", parsed_pkt_byte_len, 60);
        check("t1_words", parsed_pkt_word_len, 8);
        auto_pop = 1'b1;
        for (int i = 0; i < 6; i++) send_word(8'h00, 64'(i));
        send_word(8'h01, 64'hAA);
        idle(3);
        check("t1_err_count", err_seen, 0);

        // Directed header vectors, including errors and field-width boundaries.
        for (int v = 0; v < 8; v++) begin
            err_before = err_seen;
            expect_entry(vecs[v].dst, vecs[v].bytes, vecs[v].words);
            send_pkt(vecs[v].ctrl, mk_hdr(vecs[v].dp, vecs[v].wl, vecs[v].bl));
            idle(4);
            check($sformatf("vec%0d_err", v), err_seen - err_before, vecs[v].err);
        end
        drain();
        check("vec_err_total", err_seen, 5);

        // Fill the FIFO without popping, then overflow it.
        auto_pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_entry(3'(i), 11'(10 * (i + 1)), 8'(i + 2));
            send_pkt(8'hFF, mk_hdr(16'(1 << i), 16'(i + 2), 16'(10 * (i + 1))));
            if (i == 1) begin
                @(posedge clk);
                #1;
                check("fill_rdy_cnt2", in_rdy, 1);
            end
            if (i == 2) begin
                @(posedge clk);
                #1;
                check("fill_rdy_cnt3", in_rdy, 0);
            end
        end
        send_pkt(8'hFF, mk_hdr(16'h0001, 16'd2, 16'd5));
        idle(3);
        check("ovf_pulses", overflow_seen, 1);
        check("ovf_avail", dst_oq_avail, 1);
        check("ovf_in_rdy", in_rdy, 0);
        check("ovf_head_dst", parsed_dst_oq, 0);
        check("ovf_head_bytes", parsed_pkt_byte_len, 10);
        drain();

        // Pop and write in the same cycle with one entry stored.
        auto_pop = 1'b0;
        expect_entry(3'd3, 11'd200, 8'd25);
        send_pkt(8'hFF, mk_hdr(16'h0008, 16'd25, 16'd200));
        idle(3);
        expect_entry(3'd4, 11'd333, 8'd42);
        send_word(8'hFF, mk_hdr(16'h0010, 16'd42, 16'd333));
        @(posedge clk);
        #1;
        auto_pop = 1'b1;
        send_word(8'h00, 64'h0);
        @(posedge clk);
        #1;
        check("rw_avail", dst_oq_avail, 1);
        check("rw_head_dst", parsed_dst_oq, 4);
        check("rw_head_bytes", parsed_pkt_byte_len, 333);
        check("rw_in_rdy", in_rdy, 1);
        send_word(8'h01, 64'h0);
        idle(2);
        drain();

        // Reset in the middle of a payload; the next word must parse as a header.
        expect_entry(3'd1, 11'd48, 8'd6);
        send_word(8'hFF, mk_hdr(16'h0002, 16'd6, 16'd48));
        send_word(8'h00, 64'h0);
        idle(4);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid_rst_avail", dst_oq_avail, 0);
        check("mid_rst_in_rdy", in_rdy, 1);
        expect_entry(3'd3, 11'd77, 8'd10);
        send_pkt(8'hFF, mk_hdr(16'h0008, 16'd10, 16'd77));
        idle(3);
        drain();
        check("final_err_total", err_seen, 5);
        check("final_ovf_total", overflow_seen, 1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/oq_header_parser.md
Name: oq_header_parser

Overview:
- Sits directly upstream of the SRAM store stage in the round-robin output-queue pipeline.
- Snoops the packet stream on its way into the input FIFO. It decodes the IOQ module header, which is the first word of every packet.
- Pushes one {dst_oq, byte_len, word_len} entry per packet into a small first-word-fallthrough FIFO, which the store stage pops with rd_dst_oq.
- Produces upstream backpressure and header-error pulses.

Parameters:
- DATA_WIDTH, 64, packet data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, control bus width.
- NUM_OUTPUT_QUEUES, 5, number of output queues.
- PKT_LEN_WIDTH, 11, byte-length field width.
- PKT_WORDS_WIDTH, PKT_LEN_WIDTH-log2(CTRL_WIDTH), word-length field width.
- NUM_OQ_WIDTH, log2(NUM_OUTPUT_QUEUES), queue index width.
- IOQ_HDR_CTRL, 8'hFF, ctrl value that identifies the IOQ length/port header.
- DST_FIFO_DEPTH_BITS, 2, log2 of the entry FIFO depth (default 4 entries).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_wr  in  1  input word valid; snooped write strobe of the input FIFO.
- in_data  in  DATA_WIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input ctrl.
- in_rdy  out  1  upstream may write.
- dst_oq_avail  out  1  entry FIFO not empty.
- parsed_dst_oq  out  NUM_OQ_WIDTH  head-entry destination queue.
- parsed_pkt_byte_len  out  PKT_LEN_WIDTH  head-entry byte length.
- parsed_pkt_word_len  out  PKT_WORDS_WIDTH  head-entry word length.
- rd_dst_oq  in  1  pop the head entry.
- hdr_err  out  1  one-cycle pulse: malformed or missing header.
- entry_overflow  out  1  one-cycle pulse: entry lost because the FIFO was full.

Behaviour:
- Header word fields:
  - dst_port one-hot in [63:48].
  - word_len in [47:32].
  - src_port in [31:16] (ignored).
  - byte_len in [15:0].
- State machine:
  - ST_HDR (reset state): on in_wr, parse the word as a header and go to ST_PAYLOAD.
  - ST_PAYLOAD: track prev_ctrl_is_0, updated only on in_wr. eop = in_wr && prev_ctrl_is_0 && in_ctrl!=0. On eop, return to ST_HDR.
- dst_oq = index of the lowest set bit of dst_port[NUM_OUTPUT_QUEUES-1:0]; multicast is not supported, so higher bits are ignored.
- Error conditions. Any of the following still pushes an entry (dst_oq=0, lengths as parsed, or 0 if ctrl was wrong) and pulses hdr_err. The store stage needs exactly one entry per packet.
  - First word ctrl != IOQ_HDR_CTRL.
  - dst_port[NUM_OUTPUT_QUEUES-1:0]==0.
  - byte_len bits above PKT_LEN_WIDTH nonzero.
  - word_len bits above PKT_WORDS_WIDTH nonzero.
- Lengths are truncated to their field widths; there is no arithmetic on them.
- Latency:
  - Header accepted at edge N; fields registered at N.
  - Entry written at edge N+1; dst_oq_avail=1 after N+1.
  - hdr_err pulses in the same cycle as the entry write.
- Entry FIFO:
  - First-word-fallthrough; outputs are valid whenever dst_oq_avail=1.
  - rd_dst_oq when empty is ignored.
  - Simultaneous read and write with count>0: both occur, count unchanged.
  - Write while full (count==depth with no read that cycle): entry dropped, entry_overflow pulses, FIFO contents untouched.
- Backpressure: in_rdy = (count <= depth-2). Only one entry can be pending in the parse register, so an upstream that honours in_rdy never overflows.
- Reset:
  - state=ST_HDR, prev_ctrl_is_0=0, FIFO emptied.
  - dst_oq_avail=0, in_rdy=1, hdr_err=0, entry_overflow=0.
  - Parsed outputs read 0.
- Reset mid-packet discards the partial packet state. The next in_wr is treated as a header.
- A one-word packet (header only, then ctrl!=0 never follows a 0) stays in ST_PAYLOAD until a ctrl==0 word followed by a ctrl!=0 word arrives. Upstream guarantees at least one data word per packet.

Optional Feature:
- Macro OQ_HDR_PARSER_STATS_EN.
- When defined, add outputs:
  - num_hdrs_parsed[31:0]: incremented per entry write attempt.
  - num_hdr_errs[31:0]: incremented per hdr_err.
  - num_overflows[31:0]: incremented per entry_overflow.
  - All three wrap at 2^32, clear on reset, and each updates 1 cycle after its event.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Decomposition:
- Shared package holds:
  - IOQ_HDR_CTRL.
  - Header field bit positions (DST_PORT_POS=48, WORD_LEN_POS=32, SRC_PORT_POS=16, BYTE_LEN_POS=0, field width 16).
  - The log2 function.
- One sub-module, dst_info_fifo: parameterised FWFT FIFO with width=NUM_OQ_WIDTH+PKT_LEN_WIDTH+PKT_WORDS_WIDTH, depth 2^DST_FIFO_DEPTH_BITS, exposing count, empty and full.

Test Plan:
- Header dst_port=0x0004, byte_len=60, word_len=8, then 7 data words with last ctrl=0x01 -> after 2 cycles dst_oq_avail=1, dst_oq=2, byte_len=60, word_len=8, hdr_err=0.
- Header dst_port=0x0006 (multicast) -> dst_oq=1.
- Header dst_port=0 -> entry dst_oq=0, hdr_err pulses once.
- First word ctrl=0x00 -> entry dst_oq=0, lengths 0, hdr_err pulses once.
- Four back-to-back 2-word packets with rd_dst_oq=0 -> in_rdy deasserts once count reaches 3. Forcing a fifth header gives entry_overflow=1 and the earlier 4 entries pop intact in order.
- rd_dst_oq asserted in the same cycle as an entry write with count=1 -> count stays 1 and the head advances correctly. Reset asserted mid-payload, then a new header -> that header is parsed correctly.
